// File: rtl/systolic_matvec.sv
// -----------------------------------------------------------------------------
// systolic_matvec
//
// Multiplies one shared data word per accepted beat by a per-lane weight and
// accumulates the products in PE_NUMBER lanes. The beat enters lane 0
// directly. Data, weights and a valid tag then ripple one lane per clock, so
// lane i sees a beat i cycles after lane 0. When the final beat of a job has
// been accepted, the block waits until the skew chain has emptied. It then
// streams the PE_NUMBER accumulator values out one at a time, clears them and
// returns to idle.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : synchronous, active-low reset
//   in_valid   : input beat present
//   in_ready   : beat accepted this cycle (IDLE / RUN only)
//   in_data    : data word shared by every lane
//   in_weight  : per-lane weights, lane i at [i*WORD_SIZE +: WORD_SIZE]
//   in_last    : final beat of the current job
//   out_valid  : result present (DRAIN only)
//   out_ready  : consumer takes the result
//   out_data   : accumulator value of lane out_index
//   out_index  : lane number of out_data
//   out_last   : high with the result of the last lane
//   busy       : high in every state except IDLE
// -----------------------------------------------------------------------------
module systolic_matvec #(
   parameter int PE_NUMBER = 8,
   parameter int WORD_SIZE = 16,
   parameter int ACC_SIZE  = 40,
   parameter int SIGNED    = 1,
   localparam int IDX_W    = (PE_NUMBER > 1) ? $clog2(PE_NUMBER) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WORD_SIZE-1:0]           in_data,
   input  logic [PE_NUMBER*WORD_SIZE-1:0] in_weight,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ACC_SIZE-1:0]            out_data,
   output logic [IDX_W-1:0]               out_index,
   output logic                           out_last,
   output logic                           busy
);

   localparam int PW = 2 * WORD_SIZE;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PE_NUMBER - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [IDX_W-1:0]      k;
   logic                  accept;
   logic                  acc_clear;

   logic [ACC_SIZE-1:0]   acc    [PE_NUMBER];
   logic [WORD_SIZE-1:0]  d_pipe [PE_NUMBER-1];
   logic [PE_NUMBER-2:0]  v_pipe;

   logic [WORD_SIZE-1:0]  lane_d [PE_NUMBER];
   logic [WORD_SIZE-1:0]  lane_w [PE_NUMBER];
   logic [PE_NUMBER-1:0]  lane_v;

   // The full-width product is formed before it is extended to the accumulator
   // width. In signed mode the operands are sign-extended first, so the low
   // 2*WORD_SIZE bits are the exact two's-complement product. That product is
   // then sign-extended again to ACC_SIZE bits.
   function automatic logic [ACC_SIZE-1:0] ext_product(input logic [WORD_SIZE-1:0] d,
                                                       input logic [WORD_SIZE-1:0] w);
      logic [PW-1:0] p;
      if (SIGNED != 0) begin
         p = PW'($signed(d)) * PW'($signed(w));
         ext_product = ACC_SIZE'($signed(p));
      end else begin
         p = PW'(d) * PW'(w);
         ext_product = ACC_SIZE'(p);
      end
   endfunction

   // Control outputs and next state. In IDLE and RUN the block accepts a
   // beat. In FLUSH it waits for the skew chain to empty, and in DRAIN it
   // presents lane k. Every output stays at zero while reset is held low, even
   // before the state register has been cleared by the reset edge.
   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_index  = '0;
      out_last   = 1'b0;
      busy       = 1'b0;
      next_state = state;
      if (reset) begin
         in_ready = (state == IDLE) || (state == RUN);
         busy     = (state != IDLE);
         if (state == DRAIN) begin
            out_valid = 1'b1;
            out_index = k;
            out_data  = acc[k];
            out_last  = (k == LAST_IDX);
         end
      end
      accept    = in_valid && in_ready;
      acc_clear = out_valid && out_ready && (k == LAST_IDX);
      case (state)
         IDLE:    if (accept) next_state = in_last ? FLUSH : RUN;
         RUN:     if (accept && in_last) next_state = FLUSH;
         FLUSH:   if (k == LAST_IDX) next_state = DRAIN;
         DRAIN:   if (acc_clear) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Shared counter k. In FLUSH it counts the PE_NUMBER cycles needed for the
   // last beat to reach the final lane. It wraps to 0 on the way into DRAIN,
   // where it becomes the index of the lane being presented. It only advances
   // in DRAIN when the consumer takes a result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         k <= '0;
      end else begin
         case (state)
            FLUSH:   k <= (k == LAST_IDX) ? '0 : k + IDX_W'(1);
            DRAIN:   if (out_ready) k <= (k == LAST_IDX) ? '0 : k + IDX_W'(1);
            default: k <= '0;
         endcase
      end
   end

   // Valid tags of the skew chain. A bubble enters as a zero tag, so a lane
   // that sees it leaves its accumulator unchanged. The chain itself never
   // stalls.
   always_ff @(posedge clk) begin
      if (!reset) begin
         v_pipe <= '0;
      end else begin
         v_pipe[0] <= accept;
         for (int j = 1; j < PE_NUMBER - 1; j++) v_pipe[j] <= v_pipe[j-1];
      end
   end

   // Data words travel next to the tags. They need no reset because the tags
   // decide whether the data is used.
   always_ff @(posedge clk) begin
      d_pipe[0] <= in_data;
      for (int j = 1; j < PE_NUMBER - 1; j++) d_pipe[j] <= d_pipe[j-1];
   end

   // Per-lane operand selection. Lane 0 uses the live input. Lane i uses the
   // data and tag that are i stages down the chain, together with its own
   // weight delayed by the same i cycles.
   for (genvar i = 0; i < PE_NUMBER; i++) begin : g_lane
      if (i == 0) begin : g_head
         assign lane_d[0] = in_data;
         assign lane_w[0] = in_weight[0 +: WORD_SIZE];
         assign lane_v[0] = accept;
      end else begin : g_tail
         logic [WORD_SIZE-1:0] w_dly [i];

         // Delay line for this lane's weight. It must keep pace with the
         // data chain.
         always_ff @(posedge clk) begin
            w_dly[0] <= in_weight[i*WORD_SIZE +: WORD_SIZE];
            for (int j = 1; j < i; j++) w_dly[j] <= w_dly[j-1];
         end

         assign lane_d[i] = d_pipe[i-1];
         assign lane_w[i] = w_dly[i-1];
         assign lane_v[i] = v_pipe[i-1];
      end
   end

   // Accumulators. Each lane adds its product when its tag is set, and the
   // sum wraps modulo 2^ACC_SIZE. Every lane is cleared by reset and by the
   // final drain handshake, so the next job starts from zero.
   always_ff @(posedge clk) begin
      if (!reset || acc_clear) begin
         for (int i = 0; i < PE_NUMBER; i++) acc[i] <= '0;
      end else begin
         for (int i = 0; i < PE_NUMBER; i++)
            if (lane_v[i]) acc[i] <= acc[i] + ext_product(lane_d[i], lane_w[i]);
      end
   end

endmodule

// File: tb/tb_systolic_matvec.sv
// -----------------------------------------------------------------------------
// tb_systolic_matvec
//
// Directed bench for systolic_matvec with 4 lanes, 16-bit words, 40-bit
// accumulators and signed operands. A table of short jobs is applied in a
// loop. Hand-written sequences then cover bubbles, consumer back-pressure,
// in_valid held through flush/drain, and reset in the middle of a job.
// -----------------------------------------------------------------------------
module tb_systolic_matvec;

   localparam int PE = 4;
   localparam int W  = 16;
   localparam int A  = 40;

   typedef logic [PE-1:0][A-1:0] exp_t;

   typedef struct {
      string             name;
      logic              use_a;
      logic [W-1:0]      d_a;
      logic [PE*W-1:0]   w_a;
      logic [W-1:0]      d_b;
      logic [PE*W-1:0]   w_b;
      exp_t              expect_acc;
   } job_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    in_data = '0;
   logic [PE*W-1:0] in_weight = '0;
   logic            in_last = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [A-1:0]    out_data;
   logic [1:0]      out_index;
   logic            out_last;
   logic            busy;

   int checks = 0;
   int failures = 0;

   job_t jobs [3];

   systolic_matvec #(
      .PE_NUMBER(PE),
      .WORD_SIZE(W),
      .ACC_SIZE (A),
      .SIGNED   (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_weight(in_weight),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_index(out_index),
      .out_last (out_last),
      .busy     (busy)
   );

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   // Packs four lane weights, with lane 0 in the low bits.
   function automatic logic [PE*W-1:0] pw(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                          input logic [W-1:0] w2, input logic [W-1:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   // Packs the four expected lane results, with lane 0 in the low bits.
   function automatic exp_t ex(input logic [A-1:0] e0, input logic [A-1:0] e1,
                               input logic [A-1:0] e2, input logic [A-1:0] e3);
      exp_t e;
      e[0] = e0;
      e[1] = e1;
      e[2] = e2;
      e[3] = e3;
      return e;
   endfunction

   // Compares one value and counts it. A mismatch is reported on one line.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one cycle of input on the falling edge. The DUT samples it on the
   // following rising edge.
   task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                                input logic [PE*W-1:0] w, input logic last);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_weight = w;
      in_last   = last;
   endtask

   // Call this right after the last beat has been driven. It expects the
   // first result 5 cycles later and checks every lane in order. If
   // stall_lane is a lane number, that lane's result is held for 5 cycles
   // with out_ready low. If hold_valid is set, in_valid (and in_last) stay
   // high throughout, and in_ready must stay low.
   task automatic drain_job(input string name, input exp_t e, input int stall_lane,
                            input logic hold_valid);
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (!hold_valid) in_valid = 1'b0;
         else checkOutput({name, " in_ready in flush"}, 64'(in_ready), 64'd0);
         seen = out_valid;
      end
      checkOutput({name, " first result latency"}, 64'(n), 64'd5);
      for (int k = 0; k < PE; k++) begin
         if (k == stall_lane) begin
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               checkOutput($sformatf("%s stall%0d index", name, s), 64'(out_index), 64'(k));
               checkOutput($sformatf("%s stall%0d data", name, s), 64'(out_data), 64'(e[k]));
            end
            out_ready = 1'b1;
         end
         checkOutput($sformatf("%s lane%0d valid", name, k), 64'(out_valid), 64'd1);
         checkOutput($sformatf("%s lane%0d index", name, k), 64'(out_index), 64'(k));
         checkOutput($sformatf("%s lane%0d data", name, k), 64'(out_data), 64'(e[k]));
         checkOutput($sformatf("%s lane%0d last", name, k), 64'(out_last), 64'(k == PE - 1));
         if (hold_valid)
            checkOutput($sformatf("%s lane%0d in_ready", name, k), 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checkOutput({name, " idle busy"}, 64'(busy), 64'd0);
      checkOutput({name, " idle out_valid"}, 64'(out_valid), 64'd0);
      checkOutput({name, " idle in_ready"}, 64'(in_ready), 64'd1);
   endtask

   // Main sequence: reset, the table of jobs, then the multi-cycle corner
   // cases.
   initial begin
      int vcount;

      jobs[0] = '{name: "job d3", use_a: 1'b0, d_a: '0, w_a: '0,
                  d_b: 16'd3, w_b: pw(16'd1, 16'd2, 16'd3, 16'd4),
                  expect_acc: ex(40'd3, 40'd6, 40'd9, 40'd12)};
      jobs[1] = '{name: "job two beats", use_a: 1'b1,
                  d_a: 16'hFFFE, w_a: pw(16'd1, 16'hFFFF, 16'd100, 16'h7FFF),
                  d_b: 16'h8000, w_b: pw(16'h8000, 16'd1, 16'd0, 16'hFFFF),
                  expect_acc: ex(40'h003FFFFFFE, 40'hFFFFFF8002, 40'hFFFFFFFF38, 40'hFFFFFF8002)};
      jobs[2] = '{name: "job extremes", use_a: 1'b0, d_a: '0, w_a: '0,
                  d_b: 16'h7FFF, w_b: pw(16'h7FFF, 16'h8000, 16'd2, 16'd0),
                  expect_acc: ex(40'h003FFF0001, 40'hFFC0008000, 40'h000000FFFE, 40'd0)};

      // Hold reset for three cycles. Every output must read zero.
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("reset outputs c%0d", c),
                     64'({in_ready, out_valid, out_last, busy, out_index, out_data}), 64'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      checkOutput("release in_ready", 64'(in_ready), 64'd1);
      checkOutput("release busy", 64'(busy), 64'd0);

      // Table-driven jobs.
      for (int i = 0; i < 3; i++) begin
         if (jobs[i].use_a) applyStimulus(1'b1, jobs[i].d_a, jobs[i].w_a, 1'b0);
         applyStimulus(1'b1, jobs[i].d_b, jobs[i].w_b, 1'b1);
         drain_job(jobs[i].name, jobs[i].expect_acc, -1, 1'b0);
      end

      // A bubble between two beats must not disturb the accumulation.
      applyStimulus(1'b1, 16'd2, pw(16'd1, 16'd1, 16'd1, 16'd1), 1'b0);
      applyStimulus(1'b0, 16'd9, pw(16'd9, 16'd9, 16'd9, 16'd9), 1'b0);
      applyStimulus(1'b1, 16'hFFFF, pw(16'd5, 16'd5, 16'd5, 16'd5), 1'b1);
      drain_job("bubble", ex(40'hFFFFFFFFFD, 40'hFFFFFFFFFD, 40'hFFFFFFFFFD, 40'hFFFFFFFFFD),
                -1, 1'b0);

      // Back-pressure on the lane-1 result.
      applyStimulus(1'b1, 16'd3, pw(16'd1, 16'd2, 16'd3, 16'd4), 1'b1);
      drain_job("stall", ex(40'd3, 40'd6, 40'd9, 40'd12), 1, 1'b0);

      // in_valid and in_last stay high through flush and drain. The next job
      // must start from cleared accumulators.
      applyStimulus(1'b1, 16'd3, pw(16'd1, 16'd2, 16'd3, 16'd4), 1'b1);
      drain_job("hold valid", ex(40'd3, 40'd6, 40'd9, 40'd12), -1, 1'b1);
      applyStimulus(1'b1, 16'd1, pw(16'd7, 16'd7, 16'd7, 16'd7), 1'b1);
      drain_job("after hold", ex(40'd7, 40'd7, 40'd7, 40'd7), -1, 1'b0);

      // Reset after two beats of an intended four-beat job.
      applyStimulus(1'b1, 16'd5, pw(16'd1, 16'd2, 16'd3, 16'd4), 1'b0);
      applyStimulus(1'b1, 16'd6, pw(16'd1, 16'd1, 16'd1, 16'd1), 1'b0);
      @(negedge clk);
      checkOutput("mid-run busy", 64'(busy), 64'd1);
      in_valid = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      checkOutput("mid-run reset outputs",
                  64'({in_ready, out_valid, out_last, busy, out_index, out_data}), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("after reset in_ready", 64'(in_ready), 64'd1);
      checkOutput("after reset busy", 64'(busy), 64'd0);
      vcount = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) vcount++;
      end
      checkOutput("abandoned job out_valid count", 64'(vcount), 64'd0);
      applyStimulus(1'b1, 16'd1, pw(16'd1, 16'd1, 16'd1, 16'd1), 1'b1);
      drain_job("post reset", ex(40'd1, 40'd1, 40'd1, 40'd1), -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
